// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the inference-pipeline layer sequencer.
package layer_seq_pkg;

  localparam int unsigned NUM_LAYERS_DEFAULT = 5;

  localparam int unsigned L_CONV1 = 0;
  localparam int unsigned L_POOL1 = 1;
  localparam int unsigned L_CONV2 = 2;
  localparam int unsigned L_POOL2 = 3;
  localparam int unsigned L_FC    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StArm,
    StRun,
    StRelease,
    StFinish,
    StError
  } seq_state_t;

endpackage

// File: rtl/layer_watchdog.sv
// Saturating 32-bit per-layer cycle counter with a timeout compare.
module layer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count,
  output logic        expired
);

  logic [31:0] count_q, count_d, base;

  // With clr and en together the clearing cycle counts as the first cycle.
  always_comb begin
    base    = clr ? 32'd0 : count_q;
    count_d = base;
    if (en && (base != '1)) begin
      count_d = base + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/layer_sequencer.sv
// Runs the layer engines in index order over start/done handshakes, masking stale
// done flags for an arm window and guarding each layer with a watchdog.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = NUM_LAYERS_DEFAULT,
  parameter int unsigned ARM_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned LW             = $clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LW-1:0]         err_layer,
  output logic [LW-1:0]         cur_layer,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [31:0]           last_cycles,
  output logic [31:0]           total_cycles
);

  seq_state_t            state_q, state_d;
  logic                  start_q;
  logic [LW-1:0]         cur_q, cur_d, err_layer_q, err_layer_d;
  logic [NUM_LAYERS-1:0] ls_q, ls_d;
  logic                  done_q, done_d, error_q, error_d;
  logic [31:0]           last_q, last_d, total_q, total_d, arm_q, arm_d;
  logic                  total_en, total_clr;
  logic                  wd_clr, wd_en, wd_expired;
  logic [31:0]           wd_count;

  layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .count  (wd_count),
    .expired(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    ls_d        = ls_q;
    done_d      = done_q;
    error_d     = error_q;
    err_layer_d = err_layer_q;
    last_d      = last_q;
    arm_d       = arm_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    total_en    = 1'b0;
    total_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !start_q) begin
          state_d   = StIssue;
          cur_d     = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          total_clr = 1'b1;
        end
      end
      StIssue: begin
        total_en = 1'b1;
        wd_clr   = 1'b1;
        wd_en    = 1'b1;
        arm_d    = '0;
        if (abort) begin
          state_d = StError;
        end else begin
          ls_d        = '0;
          ls_d[cur_q] = 1'b1;
          state_d     = StArm;
        end
      end
      StArm: begin
        total_en = 1'b1;
        wd_en    = 1'b1;
        if (abort) begin
          state_d = StError;
        end else if (arm_q == ARM_CYCLES - 1) begin
          state_d = StRun;
        end else begin
          arm_d = arm_q + 32'd1;
        end
      end
      StRun: begin
        total_en = 1'b1;
        wd_en    = 1'b1;
        if (abort) begin
          state_d = StError;
        end else if (layer_done[cur_q]) begin
          last_d  = wd_count;
          state_d = StRelease;
        end else if (wd_expired) begin
          state_d = StError;
        end
      end
      StRelease: begin
        total_en = 1'b1;
        ls_d     = '0;
        if (cur_q == LW'(NUM_LAYERS - 1)) begin
          state_d = StFinish;
        end else begin
          cur_d   = cur_q + 1'b1;
          state_d = StIssue;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StError: begin
        ls_d        = '0;
        error_d     = 1'b1;
        done_d      = 1'b1;
        err_layer_d = cur_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (total_clr) begin
      total_d = '0;
    end else if (total_en && (total_q != '1)) begin
      total_d = total_q + 32'd1;
    end else begin
      total_d = total_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      cur_q       <= '0;
      ls_q        <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
      last_q      <= '0;
      total_q     <= '0;
      arm_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      cur_q       <= cur_d;
      ls_q        <= ls_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_layer_q <= err_layer_d;
      last_q      <= last_d;
      total_q     <= total_d;
      arm_q       <= arm_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign error        = error_q;
  assign err_layer    = err_layer_q;
  assign cur_layer    = cur_q;
  assign layer_start  = ls_q;
  assign last_cycles  = last_q;
  assign total_cycles = total_q;

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Top-level scheduler for the inference pipeline. It runs the layer engines (conv1, pool1, conv2, pool2, fc, …) one after another over their level start/done handshakes. Each engine holds a sticky `done` that clears only when it sees its next `start`, so the sequencer masks stale `done` during an arm window. It also guards every layer with a watchdog and reports per-layer and total cycle counts.

## Interface
Parameters:
- `NUM_LAYERS`, default 5: number of engines sequenced, in index order 0..N-1.
- `ARM_CYCLES`, default 2: cycles `layer_done[k]` is ignored after `layer_start[k]` rises. Must be ≥1.
- `TIMEOUT_CYCLES`, default 2^20: watchdog limit per layer, counted from the rise of `layer_start[k]`.
- `LW`, default `$clog2(NUM_LAYERS)`: layer index width.

Ports:
- `clk`, in, 1: clock. One clock domain only.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: run request. Only a rising edge is acted on.
- `abort`, in, 1: abandon the run in progress.
- `busy`, out, 1: high from ISSUE through FINISH/ERROR.
- `done`, out, 1: sticky. Set at the end of a run; cleared on the next accepted `start`.
- `error`, out, 1: sticky. Same clear rule as `done`.
- `err_layer`, out, `LW`: layer active when the error occurred.
- `cur_layer`, out, `LW`: index of the layer currently being run.
- `layer_start`, out, `NUM_LAYERS`: one-hot or zero, registered.
- `layer_done`, in, `NUM_LAYERS`: engine done flags.
- `last_cycles`, out, 32: length of the most recently completed layer, from `layer_start` rise to `done` sampled.
- `total_cycles`, out, 32: cycles since the accepted `start`. Frozen at FINISH/ERROR.

## Operation
- Reset (`reset_n` low, asynchronous): state IDLE; all outputs 0; `start_q` = 0.
- States: IDLE, ISSUE, ARM, RUN, RELEASE, FINISH, ERROR.
- **IDLE**
  - `start && !start_q` → ISSUE. On that edge: `cur_layer`=0, `done`=0, `error`=0, `total_cycles`=0.
  - `start` held high does not retrigger.
- **ISSUE**: `layer_start[cur_layer]`←1; watchdog cleared → ARM.
- **ARM**: hold start; `layer_done` is ignored. After `ARM_CYCLES` cycles → RUN.
- **RUN**
  - `layer_done[cur_layer]` → RELEASE; `last_cycles` ← watchdog value.
  - Else watchdog = `TIMEOUT_CYCLES-1` → ERROR.
  - `abort` (any of ISSUE/ARM/RUN) → ERROR.
  - Priority: abort > done > timeout.
- **RELEASE**: `layer_start` ← 0 for exactly one cycle.
  - Last layer → FINISH.
  - Else `cur_layer`+1 → ISSUE.
- **FINISH**: `done` ← 1, `busy` ← 0 → IDLE.
- **ERROR**: `layer_start` ← 0; `error` ← 1; `done` ← 1; `err_layer` ← `cur_layer`; `busy` ← 0 → IDLE.
- Inputs are ignored while not selected:
  - `layer_done` bits other than `cur_layer` are ignored.
  - `start` edges while busy are ignored. `start_q` still tracks, so a held `start` cannot fire later.
- Arithmetic: counters are unsigned 32-bit and saturate at 2^32-1.

## Timing
- Edge E0: `start` rise sampled.
- E1: `layer_start[0]` high.
- `layer_done[k]` is first eligible at edge E(start_k + ARM_CYCLES + 1).
- `layer_done[k]` sampled at edge N:
  - `layer_start[k]` low after N+1.
  - `layer_start[k+1]` high after N+2.
- Last layer `done` sampled at N → `done` high after N+2.
- `abort` sampled at N → every `layer_start` low and `error` high after N+1.
- `reset_n` asserted mid-run: everything clears immediately, including `layer_start`. Engines see `start` fall.

## Structure
- Package `layer_seq_pkg`:
  - `seq_state_t` enum.
  - Layer index constants: `L_CONV1`=0, `L_POOL1`=1, `L_CONV2`=2, `L_POOL2`=3, `L_FC`=4.
  - `NUM_LAYERS` default.
- Sub-module `layer_watchdog`:
  - 32-bit cycle counter with `clr`, `en`, saturation.
  - `expired` compare against `TIMEOUT_CYCLES-1`.
  - Instantiated once; also supplies `last_cycles`.

## Test plan
Unless noted, benches use `NUM_LAYERS`=3, `ARM_CYCLES`=2, `TIMEOUT_CYCLES`=64.
1. **Normal run.** Engine models assert `done` 10/20/5 cycles after `start` → `layer_start` pulses 0,1,2 in order, each low ≥1 cycle between. `last_cycles` ends at 5; `done`=1, `error`=0.
2. **Stale done.** `layer_done[1]` held high from before its start, dropping 1 cycle after `layer_start[1]` rises, re-asserting at +15 → the stale done is ignored; layer 1 ends at +15.
3. **Timeout.** Layer 1 never done → `error`=1, `err_layer`=1, `layer_start`=0, `done`=1, 64 cycles after `layer_start[1]` rises.
4. **Abort.** `abort` in RUN of layer 2, same cycle as `layer_done[2]` → ERROR (abort wins); `err_layer`=2.
5. **Retrigger and reset.**
   - `start` held high across FINISH → no second run.
   - `start` toggled low→high while busy → ignored.
   - `reset_n` low mid-layer-1 → all outputs 0 immediately.
